// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encodings, frame size, default timing and parity helper.
// Used by the host transmitter and the frame receiver.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int FRAME_BITS = 11;

  localparam int DEF_INHIBIT_CYCLES = 12000;
  localparam int DEF_START_TIMEOUT  = 1500000;
  localparam int DEF_BIT_TIMEOUT    = 200000;
  localparam int DEF_FILTER_LEN     = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus FILTER_LEN-sample glitch filter; lvl lags the pin by 2+FILTER_LEN cycles.
// fall is a 1-cycle strobe on the filtered 1->0 transition; no backpressure.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      lvl  <= 1'b1;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      fall <= 1'b0;
      // any sample agreeing with the current level restarts the run
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        lvl  <= sync[1];
        fall <= lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// One byte in flight; tx_ready only in IDLE, tx_valid otherwise ignored; done/err pulse once per byte.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int BIT_TIMEOUT    = DEF_BIT_TIMEOUT,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, BIT_TIMEOUT) + 1);

  logic [2:0]    st;
  logic [9:0]    sh;
  logic [3:0]    bc;
  logic [TW-1:0] tmr;
  logic          ack_ok;
  logic          tmr_zero;

  logic clk_f, clk_fall;
  logic data_f, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps2_clk_in),
    .lvl   (clk_f),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps2_data_in),
    .lvl   (data_f),
    .fall  (data_fall_unused)
  );

  assign tx_ready = (st == ST_IDLE);
  assign busy     = ~tx_ready;
  assign tmr_zero = (tmr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      sh          <= '0;
      bc          <= '0;
      tmr         <= '0;
      ack_ok      <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (!tmr_zero) tmr <= tmr - 1'b1;

      case (st)
        ST_IDLE: begin
          if (tx_valid) begin
            sh          <= {1'b1, odd_parity(tx_data), tx_data};
            bc          <= '0;
            tmr         <= TW'(INHIBIT_CYCLES);
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            st          <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // start bit goes down one cycle before the clock is released
          if (ps2_data_oe) begin
            ps2_clk_oe <= 1'b0;
            tmr        <= TW'(START_TIMEOUT);
            st         <= ST_REQ;
          end else if (tmr_zero) begin
            ps2_data_oe <= 1'b1;
          end
        end
        ST_REQ: begin
          if (clk_fall) begin
            ps2_data_oe <= ~sh[0];
            bc          <= 4'd1;
            tmr         <= TW'(BIT_TIMEOUT);
            st          <= ST_SHIFT;
          end else if (tmr_zero) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            st          <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            tmr <= TW'(BIT_TIMEOUT);
            if (bc == 4'(FRAME_BITS - 1)) begin
              st <= ST_ACK;
            end else begin
              ps2_data_oe <= ~sh[bc];
              bc          <= bc + 1'b1;
            end
          end else if (tmr_zero) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            st          <= ST_IDLE;
          end
        end
        ST_ACK: begin
          ack_ok <= ~data_f;
          tmr    <= TW'(BIT_TIMEOUT);
          st     <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_f && data_f) begin
            tx_done <= ack_ok;
            tx_err  <= ~ack_ok;
            st      <= ST_IDLE;
          end else if (tmr_zero) begin
            tx_err <= 1'b1;
            st     <= ST_IDLE;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          st          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model clocking the bus and sampling on rising edges.
// Timing parameters are scaled down so every scenario fits a short run.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int STO = 300;
  localparam int BTO = 200;
  localparam int FL  = 8;
  localparam int H   = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       bclk = 1'b1;
  logic       bdat = 1'b1;
  logic       glitch = 1'b0;
  logic       line_clk, line_dat;

  int nvec = 0;
  int nmis = 0;
  int ndone = 0;
  int nerr = 0;

  assign line_clk = ~ps2_clk_oe & bclk & ~glitch;
  assign line_dat = ~ps2_data_oe & bdat;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .BIT_TIMEOUT    (BTO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (line_clk),
    .ps2_data_in (line_dat),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) ndone++;
    if (tx_err) nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // device side: waits for request-to-send, then clocks up to 11 bits; stop_at aborts before that clock
  task automatic bfm(input int stop_at, input bit ack, input int glitch_at, output logic [9:0] cap);
    int t;
    cap = '0;
    t = 0;
    while (!(line_clk === 1'b1 && line_dat === 1'b0) && t < 2000) begin
      tick(1);
      t++;
    end
    chk("req_seen", 32'(t < 2000), 1);
    if (t >= 2000) return;
    tick(H);
    for (int i = 1; i <= 11; i++) begin
      if (i == stop_at) return;
      bclk = 1'b0;
      tick(H);
      bclk = 1'b1;
      if (i <= 10) cap[i-1] = line_dat;
      if (i == 10 && ack) bdat = 1'b0;
      if (i == glitch_at) begin
        tick(H / 2);
        glitch = 1'b1;
        tick(3);
        glitch = 1'b0;
        tick(H - H / 2 - 3);
      end else begin
        tick(H);
      end
      if (i == 11) bdat = 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    int n;

    rst_n = 1'b0;
    tick(3);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done_err", {tx_done, tx_err}, 0);
    rst_n = 1'b1;
    tick(2);

    // 0xED acknowledged
    ndone = 0; nerr = 0;
    send(8'hED);
    chk("t1_busy", busy, 1);
    bfm(0, 1'b1, 0, cap);
    tick(20);
    chk("t1_data", cap[7:0], 8'hED);
    chk("t1_parity", cap[8], 1);
    chk("t1_stop", cap[9], 1);
    chk("t1_done_cnt", ndone, 1);
    chk("t1_err_cnt", nerr, 0);
    chk("t1_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("t1_ready", tx_ready, 1);

    // 0xF4, inhibit length and start-bit ordering
    ndone = 0; nerr = 0;
    send(8'hF4);
    n = 1;
    while (ps2_clk_oe && !ps2_data_oe && n < 5000) begin
      tick(1);
      n++;
    end
    chk("t2_clk_low_at_start", ps2_clk_oe, 1);
    chk("t2_start_driven", ps2_data_oe, 1);
    chk("t2_inhibit_len_ok", 32'(n >= INH), 1);
    bfm(0, 1'b1, 0, cap);
    tick(20);
    chk("t2_data", cap[7:0], 8'hF4);
    chk("t2_parity", cap[8], 0);
    chk("t2_done_cnt", ndone, 1);

    // 0x00 with ACK withheld
    ndone = 0; nerr = 0;
    send(8'h00);
    bfm(0, 1'b0, 0, cap);
    tick(20);
    chk("t3_data", cap[7:0], 8'h00);
    chk("t3_parity", cap[8], 1);
    chk("t3_err_cnt", nerr, 1);
    chk("t3_done_cnt", ndone, 0);

    // device never clocks: start timeout
    ndone = 0; nerr = 0;
    send(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      tick(1);
      n++;
    end
    n = 0;
    while (!tx_err && n < 1000) begin
      tick(1);
      n++;
    end
    chk("t4_timeout_cycles", n, STO + 1);
    chk("t4_released", {ps2_clk_oe, ps2_data_oe}, 0);
    tick(5);
    chk("t4_err_cnt", nerr, 1);
    chk("t4_done_cnt", ndone, 0);
    chk("t4_ready", tx_ready, 1);

    // reset after the 4th device clock, then a clean 0xFF
    ndone = 0; nerr = 0;
    send(8'h33);
    bfm(5, 1'b1, 0, cap);
    chk("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    tick(1);
    chk("t5_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("t5_ready", tx_ready, 1);
    rst_n = 1'b1;
    tick(100);
    chk("t5_no_pulse", ndone + nerr, 0);
    send(8'hFF);
    bfm(0, 1'b1, 0, cap);
    tick(20);
    chk("t5_data", cap[7:0], 8'hFF);
    chk("t5_parity", cap[8], 1);
    chk("t5_done_cnt", ndone, 1);

    // tx_valid held with a new byte during the frame, plus a 3-cycle clock glitch
    ndone = 0; nerr = 0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'h3C;
    fork
      bfm(0, 1'b1, 3, cap);
      begin
        tick(300);
        tx_valid = 1'b0;
      end
    join
    tick(20);
    chk("t6_data", cap[7:0], 8'hA5);
    chk("t6_parity", cap[8], 1);
    chk("t6_stop", cap[9], 1);
    chk("t6_done_cnt", ndone, 1);
    chk("t6_err_cnt", nerr, 0);
    chk("t6_idle_after", {ps2_clk_oe, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
